// File: rtl/shift_add_mac_seq.sv
// ---------------------------------------------------------------------------
// shift_add_mac_seq
//   Sequential shift-add multiplier with a built-in wide accumulator. One
//   multiplier bit is retired per TEST -> (ADD) -> SHIFT pass. Every completed
//   product is latched on `product` and summed into `acc`. `ovf` is sticky.
//
//   Optional feature (compile-time macro SHIFT_ADD_MAC_SIGNED_EN):
//     undefined : unsigned operands, ovf = carry out of acc
//     defined   : two's-complement operands handled as sign-magnitude,
//                 acc sign-extended, ovf = signed overflow of acc
//
// Ports
//   clk      in   1          rising-edge clock
//   reset    in   1          asynchronous, active-low reset
//   start    in   1          request multiply (sampled only in IDLE)
//   a        in   WIDTH      multiplicand (captured in LOAD)
//   b        in   WIDTH      multiplier   (captured in LOAD)
//   acc_clr  in   1          clear acc/ovf (honoured in IDLE or DONE)
//   busy     out  1          state != IDLE
//   done     out  1          one-cycle pulse in DONE
//   product  out  2*WIDTH    last completed product
//   acc      out  ACC_WIDTH  running sum of products (wraps)
//   ovf      out  1          sticky accumulator overflow
// ---------------------------------------------------------------------------
module shift_add_mac_seq #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   acc_clr,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product,
  output logic [ACC_WIDTH-1:0]   acc,
  output logic                   ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   a_reg, p_reg, q_reg;
  logic               c_reg;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] mag;        // {C,P,Q} >> 1, i.e. the value after the final shift
  logic [2*WIDTH-1:0] prod_next;
  logic [ACC_WIDTH-1:0] acc_next;
  logic               ovf_hit;

  assign last_bit = (cnt == CNT_W'(WIDTH-1));
  assign mag      = {c_reg, p_reg, q_reg[WIDTH-1:1]};

`ifdef SHIFT_ADD_MAC_SIGNED_EN
  logic                 sgn;
  logic [ACC_WIDTH-1:0] acc_add;

  // Magnitude of the most negative value is 2^(WIDTH-1), which still fits
  // WIDTH bits when read as unsigned.
  assign a_mag     = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_mag     = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign prod_next = sgn ? (~mag + (2*WIDTH)'(1)) : mag;
  assign acc_add   = ACC_WIDTH'($signed(prod_next));
  assign acc_next  = acc + acc_add;
  assign ovf_hit   = (acc[ACC_WIDTH-1] == acc_add[ACC_WIDTH-1]) &&
                     (acc_next[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                sgn <= 1'b0;
    else if (state == S_LOAD)  sgn <= a[WIDTH-1] ^ b[WIDTH-1];
  end
`else
  logic [ACC_WIDTH:0] acc_sum;

  assign a_mag     = a;
  assign b_mag     = b;
  assign prod_next = mag;
  assign acc_sum   = {1'b0, acc} + {1'b0, ACC_WIDTH'(prod_next)};
  assign acc_next  = acc_sum[ACC_WIDTH-1:0];
  assign ovf_hit   = acc_sum[ACC_WIDTH];
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    next_state = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    case (state)
      S_IDLE:  if (start) next_state = S_LOAD;
      S_LOAD:  next_state = S_TEST;
      S_TEST:  next_state = q_reg[0] ? S_ADD : S_SHIFT;
      S_ADD:   next_state = S_SHIFT;
      S_SHIFT: next_state = last_bit ? S_DONE : S_TEST;
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;   // illegal encodings recover to IDLE
    endcase
  end

  // NOTE: all datapath registers are small flops (no memory arrays), so each
  // one is reset; a mid-operation reset leaves no partial result behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg   <= '0;
      p_reg   <= '0;
      q_reg   <= '0;
      c_reg   <= 1'b0;
      cnt     <= '0;
      product <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          a_reg <= a_mag;
          q_reg <= b_mag;
          p_reg <= '0;
          c_reg <= 1'b0;
          cnt   <= '0;
        end
        S_ADD: {c_reg, p_reg} <= {1'b0, p_reg} + {1'b0, a_reg};
        S_SHIFT: begin
          {c_reg, p_reg, q_reg} <= {1'b0, c_reg, p_reg, q_reg[WIDTH-1:1]};
          if (last_bit) begin
            cnt     <= '0;
            product <= prod_next;
            acc     <= acc_next;
            if (ovf_hit) ovf <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
      // acc is already updated on entry to DONE, so a clear there zeroes it.
      if ((state == S_IDLE || state == S_DONE) && acc_clr) begin
        acc <= '0;
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mac_seq
//   Self-checking bench for shift_add_mac_seq (WIDTH=8). The main instance
//   uses ACC_WIDTH=20; a second instance uses ACC_WIDTH=16 for wrap/ovf.
//   Expected results are pushed to a scoreboard queue when an operation is
//   launched and popped when the DUT raises done. Cycle 1 is the cycle after
//   the edge that samples start.
// ---------------------------------------------------------------------------
module tb_shift_add_mac_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, acc_clr;
  logic [7:0]  a, b;
  logic        busy, done, ovf;
  logic [15:0] product;
  logic [19:0] acc;

  logic        start16, clr16;
  logic [7:0]  a16, b16;
  logic        busy16, done16, ovf16;
  logic [15:0] product16;
  logic [15:0] acc16;

  always #5 clk = ~clk;

  shift_add_mac_seq #(.WIDTH(8), .ACC_WIDTH(20)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .acc_clr(acc_clr),
    .busy(busy), .done(done), .product(product), .acc(acc), .ovf(ovf)
  );

  shift_add_mac_seq #(.WIDTH(8), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16), .acc_clr(clr16),
    .busy(busy16), .done(done16), .product(product16), .acc(acc16), .ovf(ovf16)
  );

  typedef struct {
    logic [15:0] prod;
    logic [19:0] acc;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [19:0] model_acc;
  logic        model_ovf;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model + stimulus: compute expectation, push it, pulse start.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic clr);
    exp_t        e;
    logic [19:0] base;
    logic        base_ovf;
    logic [15:0] p;
`ifdef SHIFT_ADD_MAC_SIGNED_EN
    logic [7:0]  bm;
    logic [19:0] ext, s;
    bm       = bv[7] ? (~bv + 8'd1) : bv;
    p        = $signed(av) * $signed(bv);
    base     = clr ? 20'd0 : model_acc;
    base_ovf = clr ? 1'b0 : model_ovf;
    ext      = {{4{p[15]}}, p};
    s        = base + ext;
    e.ovf    = base_ovf | ((base[19] == ext[19]) && (s[19] != base[19]));
    e.acc    = s;
    e.cyc    = 2*8 + $countones(bm) + 2;
`else
    logic [20:0] s;
    p        = av * bv;
    base     = clr ? 20'd0 : model_acc;
    base_ovf = clr ? 1'b0 : model_ovf;
    s        = {1'b0, base} + {5'd0, p};
    e.ovf    = base_ovf | s[20];
    e.acc    = s[19:0];
    e.cyc    = 2*8 + $countones(bv) + 2;
`endif
    e.prod    = p;
    model_acc = e.acc;
    model_ovf = e.ovf;
    sb.push_back(e);
    @(negedge clk);
    a = av; b = bv; start = 1'b1; acc_clr = clr;
    @(negedge clk);
    start = 1'b0; acc_clr = 1'b0;
  endtask

  // Scoreboard consumer: waits (bounded) for done, pops and compares.
  // sp_cyc: cycle in which to pulse start while busy; cf..ct: acc_clr window.
  task automatic wait_done(input string name, input int sp_cyc, input int cf,
                           input int ct, input logic clr_in_done);
    exp_t e;
    int   cyc = 1;
    int   busy_bad = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1) busy_bad++;
      start   = (cyc == sp_cyc);
      acc_clr = (cyc >= cf && cyc <= ct);
      @(negedge clk);
      cyc++;
    end
    start   = 1'b0;
    acc_clr = clr_in_done;
    e = sb.pop_front();
    n_tests++;
    if (cyc >= 100) begin
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles, want cycle %0d", name, cyc, e.cyc);
      acc_clr = 1'b0;
      return;
    end
    if (cyc !== e.cyc) begin
      n_fail++; $display("FAIL %s_latency: got cycle %0d want %0d", name, cyc, e.cyc);
    end
    n_tests++;
    if (product !== e.prod) begin
      n_fail++; $display("FAIL %s_product: got %h want %h", name, product, e.prod);
    end
    n_tests++;
    if (acc !== e.acc) begin
      n_fail++; $display("FAIL %s_acc: got %h want %h", name, acc, e.acc);
    end
    n_tests++;
    if (ovf !== e.ovf) begin
      n_fail++; $display("FAIL %s_ovf: got %b want %b", name, ovf, e.ovf);
    end
    n_tests++;
    if (busy_bad !== 0) begin
      n_fail++; $display("FAIL %s_busy: busy low in %0d cycles want 0", name, busy_bad);
    end
    @(negedge clk);
    acc_clr = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL %s_idle: got busy=%b done=%b want 0 0", name, busy, done);
    end
    if (clr_in_done) begin
      model_acc = '0;
      model_ovf = 1'b0;
      n_tests++;
      if (acc !== 20'd0 || ovf !== 1'b0) begin
        n_fail++; $display("FAIL %s_clr_done: got acc=%h ovf=%b want 0 0", name, acc, ovf);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++;
    if (product !== 16'd0) begin n_fail++; $display("FAIL reset_product: got %h want 0", product); end
    n_tests++;
    if (acc !== 20'd0) begin n_fail++; $display("FAIL reset_acc: got %h want 0", acc); end
    n_tests++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    model_acc = '0;
    model_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    launch(8'd13, 8'd11, 1'b0);
    wait_done("basic_13x11", -1, 0, -1, 1'b0);
  endtask

  task automatic test_max();
    launch(8'd255, 8'd255, 1'b1);           // clear with start: sum restarts at 0
    wait_done("max_first", -1, 0, -1, 1'b0);
    launch(8'd255, 8'd255, 1'b0);
    wait_done("max_second", -1, 0, -1, 1'b0);
  endtask

  task automatic test_zero_busy_start();
    int extra = 0;
    launch(8'd200, 8'd0, 1'b0);
    wait_done("zero_b", 5, 0, -1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++; $display("FAIL busy_start_ignored: got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_acc_clr();
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    model_acc = '0;
    model_ovf = 1'b0;
    n_tests++;
    if (acc !== 20'd0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL clr_idle: got acc=%h ovf=%b want 0 0", acc, ovf);
    end
    launch(8'd3, 8'd5, 1'b0);
    wait_done("clr_ignored_busy", -1, 3, 10, 1'b0);
    launch(8'd7, 8'd9, 1'b0);
    wait_done("clr_in_done", -1, 0, -1, 1'b1);
  endtask

  task automatic test_acc16();
    logic [16:0] s;
    logic [15:0] exp_acc = '0;
    logic        exp_ovf = 1'b0;
    for (int i = 0; i < 2; i++) begin
      int k = 0;
      @(negedge clk);
      a16 = 8'd255; b16 = 8'd255; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      while (done16 !== 1'b1 && k < 100) begin
        @(negedge clk);
        k++;
      end
      s       = {1'b0, exp_acc} + 17'd65025;
      exp_acc = s[15:0];
      exp_ovf = exp_ovf | s[16];
      n_tests++;
      if (k >= 100) begin
        n_fail++; $display("FAIL acc16_timeout: no done16 within %0d cycles", k);
      end else if (product16 !== 16'd65025) begin
        n_fail++; $display("FAIL acc16_product: got %0d want 65025", product16);
      end
      @(negedge clk);
    end
    n_tests++;
    if (acc16 !== exp_acc) begin n_fail++; $display("FAIL acc16_wrap: got %0d want %0d", acc16, exp_acc); end
    n_tests++;
    if (ovf16 !== exp_ovf) begin n_fail++; $display("FAIL acc16_ovf: got %b want %b", ovf16, exp_ovf); end
    clr16 = 1'b1;
    @(negedge clk);
    clr16 = 1'b0;
    n_tests++;
    if (acc16 !== 16'd0 || ovf16 !== 1'b0) begin
      n_fail++; $display("FAIL acc16_clr: got acc=%0d ovf=%b want 0 0", acc16, ovf16);
    end
  endtask

  task automatic test_midop_reset();
    launch(8'd2, 8'd3, 1'b0);
    wait_done("pre_reset", -1, 0, -1, 1'b0);
    launch(8'd13, 8'd11, 1'b0);
    for (int i = 1; i < 7; i++) @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'd0 || acc !== 20'd0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: got busy=%b done=%b product=%h acc=%h ovf=%b want all 0",
               busy, done, product, acc, ovf);
    end
    sb.delete();
    model_acc = '0;
    model_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    launch(8'd13, 8'd11, 1'b0);
    wait_done("after_reset", -1, 0, -1, 1'b0);
  endtask

`ifdef SHIFT_ADD_MAC_SIGNED_EN
  task automatic test_signed();
    launch(8'hFD, 8'd5, 1'b1);              // -3 * 5, accumulated onto a cleared acc
    wait_done("signed_m3x5", -1, 0, -1, 1'b0);
    launch(8'h80, 8'h80, 1'b0);             // -128 * -128
    wait_done("signed_min", -1, 0, -1, 1'b0);
  endtask
`endif

  initial begin
    start = 1'b0; acc_clr = 1'b0; a = '0; b = '0;
    start16 = 1'b0; clr16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_basic();
`ifdef SHIFT_ADD_MAC_SIGNED_EN
    test_signed();
`else
    test_max();
    test_acc16();
`endif
    test_zero_busy_start();
    test_acc_clr();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
